mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 6 +
 rtl/mdu_step.sv | 22 ++
 rtl/mdu.sv | 130 +++++++++++++
 tb/tb_mdu.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation/state encodings and constants for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_t;
  localparam logic [63:0] MDU_DIV0_QUOT = '1;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply or restoring shift-subtract divide iteration on magnitudes
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   m_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  // multiply: {acc_hi+m?, acc_lo} >> 1; divide: shift left, subtract divisor if it fits
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + ({1'b0, m_i} & {(WIDTH+1){acc_i[0]}});
    rem   = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = rem - {1'b0, m_i};
    acc_o = !is_div_i ? {sum, acc_i[WIDTH-1:1]} :
            diff[WIDTH] ? {rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0} :
                          {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mdu.sv
// mdu: iterative MIPS HI/LO multiply/divide unit; MDU_FAST_MULT_EN enables single-edge multiply
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_t state_q, state_d;
  mdu_op_t op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, b_zero_q, b_zero_d, done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo, rem;
  logic sgn, is_div_q, fix_neg;
  assign sgn      = ~op[0];
  assign abs_a    = (sgn & a[WIDTH-1]) ? -a : a;
  assign abs_b    = (sgn & b[WIDTH-1]) ? -b : b;
  assign is_div_q = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign fix_neg  = neg_a_q ^ neg_b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .m_i     (m_q),
    .is_div_i(is_div_q),
    .acc_o   (step_acc)
  );
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign ext_b     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign fast_prod = ext_a * ext_b;
`endif
  // next state: accept/MT writes in IDLE, iterate in CALC, sign-correct and commit in FIX
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    acc_d    = acc_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod     = fix_neg ? -acc_q : acc_q;
    quo      = b_zero_q ? MDU_DIV0_QUOT[WIDTH-1:0] :
               fix_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (state_q)
      IDLE: begin
        hi_d = hi_we ? a : hi_q;
        lo_d = lo_we ? a : lo_q;
        if (start) begin
          op_d     = mdu_op_t'(op);
          neg_a_d  = sgn & a[WIDTH-1];
          neg_b_d  = sgn & b[WIDTH-1];
          b_zero_d = b == '0;
          acc_d    = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
          m_d      = op[1] ? abs_b : abs_a;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef MDU_FAST_MULT_EN
          if (!op[1]) begin
            acc_d   = fast_prod;
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        acc_d   = step_acc;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
      end
      FIX: begin
        {hi_d, lo_d} = is_div_q ? {rem, quo} : prod;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset aborting any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MDU_MULT;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against an arithmetic reference model
module tb_mdu;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b0;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done;
  int vectors = 0, miscompares = 0;
  mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    logic [63:0] ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'd0) begin
      sp = sx * sy;
      return sp;
    end
    if (o == 2'd1) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd3) return {x % y, x / y};
    sq = sx / sy;
    sr = sx % sy;
    return {sr[31:0], sq[31:0]};
  endfunction
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit mt);
    logic [63:0] exp;
    int lat, bc;
    bit seen, ov;
    exp = model(o, x, y);
    lat = 33;
`ifdef MDU_FAST_MULT_EN
    if (!o[1]) lat = 1;
`endif
    op = o; a = x; b = y; start = 1'b1; hi_we = mt;
    tick();
    start = 1'b0; hi_we = 1'b0;
    if (mt) check({tag, "_mthi"}, {32'b0, hi}, {32'b0, x});
    op = 2'($urandom); a = $urandom; b = $urandom;
    bc = 0; seen = 0; ov = 0;
    for (int n = 0; n < 100; n++) begin
      if (busy) bc++;
      ov |= busy & done;
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busycyc"}, 64'(bc), 64'(lat));
    check({tag, "_overlap"}, 64'(ov), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    bit dn;
    tick();
    tick();
    reset = 1'b0;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", {62'd0, busy, done}, 64'd0);
    run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 0);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_div0", 2'd3, 32'h1234, 32'd0, 0);
    check("divu_div0_const", {hi, lo}, 64'h00001234_FFFFFFFF);
    run_op("div_div0_neg", 2'd2, 32'hFFFFFF00, 32'd0, 0);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_op("div_rem_sign", 2'd2, 32'd7, 32'hFFFFFFFE, 0);
    run_op("mult_min", 2'd0, 32'h80000000, 32'h80000000, 0);
    run_op("mt_start", 2'd3, 32'd100, 32'd7, 1);
    run_op("divu", 2'd3, 32'd100, 32'd7, 0);
    check("divu_const", {hi, lo}, 64'h00000002_0000000E);
    op = 2'd3; a = 32'h1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 2'd0; hi_we = 1'b1; a = 32'hAAAA;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy_mthi_ign", {32'b0, hi}, 64'd2);
    check("busy_mid", 64'(busy), 64'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_busy", {62'd0, busy, done}, 64'd0);
    dn = 0;
    repeat (40) begin
      tick();
      dn |= done | busy;
    end
    check("abort_quiet", 64'(dn), 64'd0);
    lo_we = 1'b1; a = 32'h55;
    tick();
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, 64'h00000000_00000055);
    hi_we = 1'b1; a = 32'h77;
    tick();
    hi_we = 1'b0;
    check("mthi", {hi, lo}, 64'h00000077_00000055);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFFFFFF;
        3: x = 32'h80000000;
        default: ;
      endcase
      run_op("rand", o, x, y, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
